btb_predictor: RTL and testbench
================================

# btb_predictor

Parametrised, tagged branch target buffer with 2-bit saturating direction counters. It replaces the untagged single-configuration predictor in the fetch path. The block takes a lookup PC in IF and returns a registered prediction one cycle later, while the branch is in ID. In EX it accepts the resolved branch, updates the table, detects mispredictions and produces the redirect PC. It also keeps a saturating misprediction count for performance monitoring.

## Interface
- `PC_W`, 32: PC and target width.
- `IDX_W`, 10: index bits; the table has 2^IDX_W entries.
- `TAG_W`, 8: tag bits stored per entry.
- `CNT_INIT`, 2'b01: counter value reported on a miss (weakly not-taken).
- `clk` in 1: the only clock.
- `rst` in 1: reset, synchronous and active-high.
- `stall_i` in 1: holds the lookup output register.
- `lk_pc_i` in PC_W: IF-stage fetch PC to look up.
- `id_is_branch_i` in 1: the ID-stage instruction is a branch; gates `pre_taken_o`.
- `pre_hit_o` out 1: the lookup hit a valid entry with a matching tag.
- `pre_taken_o` out 1: predicted taken.
- `pre_target_o` out PC_W: predicted target.
- `pre_counter_o` out 2: counter value; it travels down the pipeline to `upd_counter_i`.
- `upd_valid_i` in 1: a resolved branch is in EX.
- `upd_pc_i` in PC_W: PC of the resolved branch.
- `upd_taken_i` in 1: actual branch direction.
- `upd_target_i` in PC_W: actual branch target.
- `upd_counter_i` in 2: counter captured at prediction time.
- `upd_pre_taken_i` in 1: direction that was predicted.
- `upd_pre_target_i` in PC_W: target that was predicted.
- `mispredict_o` out 1: flush request.
- `redirect_pc_o` out PC_W: correct fetch PC after a misprediction.
- `mispred_cnt_o` out 32: saturating misprediction count.

## Operation
- Address fields:
  - index = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Entry contents: valid, tag, cnt[1:0], target. Valid bits are held in flops; tag, counter and target are held in arrays with one read port per consumer.
- Lookup:
  - On each edge with `!stall_i`, the entry at the lookup index and the lookup tag are captured into the output register.
  - `pre_hit_o` = valid & (stored tag == captured tag).
  - `pre_counter_o` = hit ? cnt : CNT_INIT.
  - `pre_taken_o` = hit & cnt[1] & `id_is_branch_i`.
  - `pre_target_o` = stored target when hit, else 0.
- Update (only when `upd_valid_i`):
  - new_cnt = taken ? sat_inc(`upd_counter_i`) : sat_dec(`upd_counter_i`), bounded to 00..11.
  - The hit check is done internally at the update index.
  - Hit: write new_cnt. Replace the target only when taken; on a not-taken update the stored target is kept.
  - Miss and taken: allocate the entry with valid=1, the update tag, new_cnt and `upd_target_i`. Any other entry at that index is overwritten.
  - Miss and not-taken: no write.
- Misprediction (combinational):
  - `mispredict_o` = `upd_valid_i` & ((`upd_taken_i` != `upd_pre_taken_i`) | (`upd_taken_i` & (`upd_target_i` != `upd_pre_target_i`))).
  - `redirect_pc_o` = `upd_taken_i` ? `upd_target_i` : `upd_pc_i` + 8, which skips the delay slot.
- `mispred_cnt_o` increments by 1 on every edge where `mispredict_o` = 1, and holds at 32'hFFFFFFFF.
- Write-first bypass: if an update writes the index being captured on the same edge, and `!stall_i`, the output register takes the newly written valid, tag, cnt and target.
- Stall: the output register holds its value and updates still commit. A held output is not refreshed by an update to its index.
- Reset has priority over all other activity:
  - All valid bits clear in one cycle.
  - Output register clears, giving `pre_hit_o`=0, `pre_taken_o`=0, `pre_target_o`=0 and `pre_counter_o`=CNT_INIT.
  - `mispred_cnt_o`=0.
  - Updates presented during reset are dropped.

## Timing
- Lookup latency is one cycle. A PC presented in cycle N gives a prediction valid throughout cycle N+1. `pre_taken_o` additionally follows `id_is_branch_i` combinationally.
- An update presented in cycle N is visible to lookups captured at the end of cycle N (through the bypass) and later.
- `mispredict_o` and `redirect_pc_o` are valid in the same cycle as `upd_valid_i`. The pipeline flushes IF and ID on the following edge.
- `mispred_cnt_o` reflects a misprediction one cycle after it occurs.

## Test plan
Configuration for all scenarios: IDX_W=10, TAG_W=8.
- Reset, then look up 0x00400010 -> next cycle `pre_hit_o`=0, `pre_taken_o`=0, `pre_counter_o`=01, `pre_target_o`=0.
- Update pc 0x00400010, taken, target 0x00400100, counter 01, pre_taken 0 -> that cycle `mispredict_o`=1 and `redirect_pc_o`=0x00400100. Next lookup with `id_is_branch_i`=1 gives hit 1, counter 10, taken 1, target 0x00400100. `mispred_cnt_o`=1.
- Three more taken updates on the same PC -> counter reaches 11 and stays 11. Then not-taken updates -> 10, then 01, with the target still 0x00400100 and `pre_taken_o`=0 at 01. A not-taken misprediction redirects to 0x00400018.
- Alias: pc 0x00401010 has the same index and a different tag -> lookup misses. A taken update at that PC with target 0x00402000 replaces the entry, after which a lookup of 0x00400010 misses.
- Bypass: lookup and taken update of the same PC on the same edge -> the next-cycle output already shows hit 1 and the new target. A not-taken update to an unallocated PC leaves it missing.
- Stall: hold `stall_i`=1 for 3 cycles while `lk_pc_i` changes -> outputs stay constant and updates still commit. Assert `rst` mid-stall -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/btb_predictor.sv
// Tagged branch target buffer with 2-bit saturating direction counters.
// Lookup is registered (IF -> ID). Update, mispredict detection and redirect happen in EX.
module btb_predictor #(
    parameter int          PC_W     = 32,
    parameter int          IDX_W    = 10,
    parameter int          TAG_W    = 8,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic [PC_W-1:0] lk_pc_i,
    input  logic            id_is_branch_i,
    output logic            pre_hit_o,
    output logic            pre_taken_o,
    output logic [PC_W-1:0] pre_target_o,
    output logic [1:0]      pre_counter_o,
    input  logic            upd_valid_i,
    input  logic [PC_W-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [PC_W-1:0] upd_target_i,
    input  logic [1:0]      upd_counter_i,
    input  logic            upd_pre_taken_i,
    input  logic [PC_W-1:0] upd_pre_target_i,
    output logic            mispredict_o,
    output logic [PC_W-1:0] redirect_pc_o,
    output logic [31:0]     mispred_cnt_o
);
    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] r_valid;
    logic [TAG_W-1:0] r_tag_mem [DEPTH];
    logic [1:0]       r_cnt_mem [DEPTH];
    logic [PC_W-1:0]  r_tgt_mem [DEPTH];

    logic             r_out_valid;
    logic [TAG_W-1:0] r_out_tag;
    logic [TAG_W-1:0] r_lk_tag;
    logic [1:0]       r_out_cnt;
    logic [PC_W-1:0]  r_out_tgt;
    logic [31:0]      r_mispred_cnt;

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    logic [1:0]       w_new_cnt;
    logic             w_wr_en;
    logic [PC_W-1:0]  w_wr_tgt;
    logic             w_byp;
    logic             w_ent_valid;
    logic [TAG_W-1:0] w_ent_tag;
    logic [1:0]       w_ent_cnt;
    logic [PC_W-1:0]  w_ent_tgt;
    logic             w_unused;

    assign w_lk_idx  = lk_pc_i[IDX_W+1:2];
    assign w_lk_tag  = lk_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign w_upd_idx = upd_pc_i[IDX_W+1:2];
    assign w_upd_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign w_unused  = ^{lk_pc_i[1:0], lk_pc_i[PC_W-1:IDX_W+TAG_W+2]};

    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag_mem[w_upd_idx] == w_upd_tag);

    always_comb begin
        w_new_cnt = upd_counter_i;
        if (upd_taken_i) begin
            if (upd_counter_i != 2'b11) w_new_cnt = upd_counter_i + 2'd1;
        end else if (upd_counter_i != 2'b00) begin
            w_new_cnt = upd_counter_i - 2'd1;
        end
    end

    // A not-taken hit rewrites the stored target with itself, so one write path covers all cases.
    assign w_wr_en  = upd_valid_i && !rst && (w_upd_hit || upd_taken_i);
    assign w_wr_tgt = upd_taken_i ? upd_target_i : r_tgt_mem[w_upd_idx];
    assign w_byp    = w_wr_en && (w_upd_idx == w_lk_idx);

    assign w_ent_valid = w_byp ? 1'b1      : r_valid[w_lk_idx];
    assign w_ent_tag   = w_byp ? w_upd_tag : r_tag_mem[w_lk_idx];
    assign w_ent_cnt   = w_byp ? w_new_cnt : r_cnt_mem[w_lk_idx];
    assign w_ent_tgt   = w_byp ? w_wr_tgt  : r_tgt_mem[w_lk_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_wr_en) begin
            r_valid[w_upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_tag_mem[w_upd_idx] <= w_upd_tag;
            r_cnt_mem[w_upd_idx] <= w_new_cnt;
            r_tgt_mem[w_upd_idx] <= w_wr_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_lk_tag    <= '0;
            r_out_cnt   <= CNT_INIT;
            r_out_tgt   <= '0;
        end else if (!stall_i) begin
            r_out_valid <= w_ent_valid;
            r_out_tag   <= w_ent_tag;
            r_lk_tag    <= w_lk_tag;
            r_out_cnt   <= w_ent_cnt;
            r_out_tgt   <= w_ent_tgt;
        end
    end

    assign pre_hit_o     = r_out_valid && (r_out_tag == r_lk_tag);
    assign pre_counter_o = pre_hit_o ? r_out_cnt : CNT_INIT;
    assign pre_taken_o   = pre_hit_o && r_out_cnt[1] && id_is_branch_i;
    assign pre_target_o  = pre_hit_o ? r_out_tgt : '0;

    assign mispredict_o  = upd_valid_i &&
                           ((upd_taken_i != upd_pre_taken_i) ||
                            (upd_taken_i && (upd_target_i != upd_pre_target_i)));
    // Not-taken resumes after the delay slot.
    assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + PC_W'(8);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mispred_cnt <= '0;
        end else if (mispredict_o && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
            r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign mispred_cnt_o = r_mispred_cnt;

endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor: directed walk through the main scenarios, then random traffic,
// all checked against a per-index table model.
module tb_btb_predictor;
    localparam int PC_W  = 32;
    localparam int IDX_W = 10;
    localparam int TAG_W = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall_i;
    logic [PC_W-1:0] lk_pc_i;
    logic            id_is_branch_i;
    logic            pre_hit_o;
    logic            pre_taken_o;
    logic [PC_W-1:0] pre_target_o;
    logic [1:0]      pre_counter_o;
    logic            upd_valid_i;
    logic [PC_W-1:0] upd_pc_i;
    logic            upd_taken_i;
    logic [PC_W-1:0] upd_target_i;
    logic [1:0]      upd_counter_i;
    logic            upd_pre_taken_i;
    logic [PC_W-1:0] upd_pre_target_i;
    logic            mispredict_o;
    logic [PC_W-1:0] redirect_pc_o;
    logic [31:0]     mispred_cnt_o;

    btb_predictor #(.PC_W(PC_W), .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_INIT(2'b01)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .lk_pc_i(lk_pc_i),
        .id_is_branch_i(id_is_branch_i), .pre_hit_o(pre_hit_o), .pre_taken_o(pre_taken_o),
        .pre_target_o(pre_target_o), .pre_counter_o(pre_counter_o),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
        .upd_target_i(upd_target_i), .upd_counter_i(upd_counter_i),
        .upd_pre_taken_i(upd_pre_taken_i), .upd_pre_target_i(upd_pre_target_i),
        .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
        .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one record per index, plus the expected prediction register.
    bit              m_valid [int];
    logic [TAG_W-1:0] m_tag  [int];
    logic [1:0]      m_cnt   [int];
    logic [PC_W-1:0] m_tgt   [int];
    logic            exp_hit;
    logic [1:0]      exp_cnt;
    logic [PC_W-1:0] exp_tgt;
    logic [31:0]     exp_mcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [PC_W-1:0] pc);
        return int'((pc >> 2) % (1 << IDX_W));
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [PC_W-1:0] pc);
        return TAG_W'((pc >> (IDX_W + 2)) % (1 << TAG_W));
    endfunction

    function automatic bit model_hit(input logic [PC_W-1:0] pc);
        int i = idx_of(pc);
        return m_valid.exists(i) && m_tag[i] == tag_of(pc);
    endfunction

    task automatic model_reset();
        m_valid.delete();
        m_tag.delete();
        m_cnt.delete();
        m_tgt.delete();
        exp_hit  = 1'b0;
        exp_cnt  = 2'b01;
        exp_tgt  = '0;
        exp_mcnt = 0;
    endtask

    task automatic model_update();
        int         i = idx_of(upd_pc_i);
        int         c = int'(upd_counter_i);
        logic [1:0] nc;
        if (upd_taken_i) c = (c == 3) ? 3 : c + 1;
        else             c = (c == 0) ? 0 : c - 1;
        nc = 2'(c);
        if (model_hit(upd_pc_i)) begin
            m_cnt[i] = nc;
            if (upd_taken_i) m_tgt[i] = upd_target_i;
        end else if (upd_taken_i) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(upd_pc_i);
            m_cnt[i]   = nc;
            m_tgt[i]   = upd_target_i;
        end
    endtask

    task automatic model_lookup(input logic [PC_W-1:0] pc);
        int i = idx_of(pc);
        if (model_hit(pc)) begin
            exp_hit = 1'b1;
            exp_cnt = m_cnt[i];
            exp_tgt = m_tgt[i];
        end else begin
            exp_hit = 1'b0;
            exp_cnt = 2'b01;
            exp_tgt = '0;
        end
    endtask

    // Check every output for the current cycle, advance the model across the edge, then clock.
    task automatic step();
        logic            e_mp;
        logic [PC_W-1:0] e_rd;
        #1;
        e_mp = upd_valid_i && ((upd_taken_i != upd_pre_taken_i) ||
                               (upd_taken_i && (upd_target_i != upd_pre_target_i)));
        e_rd = upd_taken_i ? upd_target_i : upd_pc_i + 32'd8;
        chk("pre_hit", pre_hit_o, exp_hit);
        chk("pre_taken", pre_taken_o, exp_hit & exp_cnt[1] & id_is_branch_i);
        chk("pre_target", pre_target_o, exp_tgt);
        chk("pre_counter", pre_counter_o, exp_cnt);
        chk("mispredict", mispredict_o, e_mp);
        chk("redirect", redirect_pc_o, e_rd);
        chk("mispred_cnt", mispred_cnt_o, exp_mcnt);
        if (rst) begin
            model_reset();
        end else begin
            if (e_mp && exp_mcnt != 32'hFFFF_FFFF) exp_mcnt++;
            if (upd_valid_i) model_update();
            if (!stall_i) model_lookup(lk_pc_i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic no_upd();
        upd_valid_i      = 1'b0;
        upd_pc_i         = '0;
        upd_taken_i      = 1'b0;
        upd_target_i     = '0;
        upd_counter_i    = 2'b00;
        upd_pre_taken_i  = 1'b0;
        upd_pre_target_i = '0;
    endtask

    task automatic upd(input logic [PC_W-1:0] pc, input logic taken, input logic [PC_W-1:0] tgt,
                       input logic [1:0] cnt, input logic ptaken, input logic [PC_W-1:0] ptgt);
        upd_valid_i      = 1'b1;
        upd_pc_i         = pc;
        upd_taken_i      = taken;
        upd_target_i     = tgt;
        upd_counter_i    = cnt;
        upd_pre_taken_i  = ptaken;
        upd_pre_target_i = ptgt;
    endtask

    function automatic logic [PC_W-1:0] rand_pc();
        logic [PC_W-1:0] pc;
        pc = 32'h0040_0000;
        pc = pc | (PC_W'($urandom_range(0, 1)) << (IDX_W + 2));
        pc = pc | (PC_W'($urandom_range(0, 3)) << 2);
        pc = pc | PC_W'($urandom_range(0, 3));
        pc = pc | (PC_W'($urandom_range(0, 1)) << 28);
        return pc;
    endfunction

    function automatic logic [PC_W-1:0] rand_tgt();
        return 32'h0040_0000 + (PC_W'($urandom_range(0, 7)) << 4);
    endfunction

    initial begin
        rst = 1'b1;
        stall_i = 1'b0;
        id_is_branch_i = 1'b1;
        lk_pc_i = '0;
        no_upd();
        @(posedge clk);
        #1;
        model_reset();
        step();
        rst = 1'b0;

        // Miss after reset.
        lk_pc_i = 32'h0040_0010;
        step();
        chk("reset_lookup_hit", pre_hit_o, 1'b0);
        chk("reset_lookup_cnt", pre_counter_o, 2'b01);
        chk("reset_lookup_tgt", pre_target_o, 32'h0);

        // First taken update allocates and mispredicts.
        lk_pc_i = 32'h0;
        upd(32'h0040_0010, 1'b1, 32'h0040_0100, 2'b01, 1'b0, 32'h0);
        #1;
        chk("alloc_mispredict", mispredict_o, 1'b1);
        chk("alloc_redirect", redirect_pc_o, 32'h0040_0100);
        step();
        no_upd();
        lk_pc_i = 32'h0040_0010;
        step();
        chk("alloc_hit", pre_hit_o, 1'b1);
        chk("alloc_cnt", pre_counter_o, 2'b10);
        chk("alloc_taken", pre_taken_o, 1'b1);
        chk("alloc_tgt", pre_target_o, 32'h0040_0100);
        chk("alloc_mcnt", mispred_cnt_o, 32'd1);

        // Saturate up, then walk down with not-taken updates.
        upd(32'h0040_0010, 1'b1, 32'h0040_0100, 2'b10, 1'b1, 32'h0040_0100); step();
        upd(32'h0040_0010, 1'b1, 32'h0040_0100, 2'b11, 1'b1, 32'h0040_0100); step();
        upd(32'h0040_0010, 1'b1, 32'h0040_0100, 2'b11, 1'b1, 32'h0040_0100); step();
        no_upd(); step();
        chk("sat_cnt", pre_counter_o, 2'b11);
        upd(32'h0040_0010, 1'b0, 32'h0, 2'b11, 1'b0, 32'h0); step();
        upd(32'h0040_0010, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0); step();
        no_upd(); step();
        chk("dec_cnt", pre_counter_o, 2'b01);
        chk("dec_taken", pre_taken_o, 1'b0);
        chk("dec_tgt_kept", pre_target_o, 32'h0040_0100);
        upd(32'h0040_0010, 1'b0, 32'h0, 2'b01, 1'b1, 32'h0040_0100);
        #1;
        chk("nt_redirect", redirect_pc_o, 32'h0040_0018);
        step();

        // Aliasing PC with a different tag.
        no_upd();
        lk_pc_i = 32'h0040_1010;
        step();
        step();
        chk("alias_miss", pre_hit_o, 1'b0);
        upd(32'h0040_1010, 1'b1, 32'h0040_2000, 2'b01, 1'b0, 32'h0);
        step();
        no_upd();
        lk_pc_i = 32'h0040_0010;
        step();
        step();
        chk("alias_evict", pre_hit_o, 1'b0);

        // Same-edge lookup and update bypass.
        upd(32'h0040_0010, 1'b1, 32'h0040_0200, 2'b01, 1'b0, 32'h0);
        step();
        no_upd();
        chk("bypass_hit", pre_hit_o, 1'b1);
        chk("bypass_tgt", pre_target_o, 32'h0040_0200);
        lk_pc_i = 32'h0040_0020;
        upd(32'h0040_0020, 1'b0, 32'h0, 2'b01, 1'b0, 32'h0);
        step();
        no_upd();
        step();
        chk("nt_no_alloc", pre_hit_o, 1'b0);

        // Stall holds the output while updates commit.
        lk_pc_i = 32'h0040_0010;
        step();
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lk_pc_i = 32'h0040_0020 + 32'(k * 4);
            upd(32'h0040_0010, 1'b1, 32'h0040_0300, 2'b10, 1'b1, 32'h0040_0300);
            step();
            chk("stall_hold_tgt", pre_target_o, 32'h0040_0200);
        end
        no_upd();
        stall_i = 1'b0;
        lk_pc_i = 32'h0040_0010;
        step();
        chk("stall_commit_tgt", pre_target_o, 32'h0040_0300);
        stall_i = 1'b1;
        lk_pc_i = 32'h0040_0040;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        stall_i = 1'b0;
        chk("stall_rst_hit", pre_hit_o, 1'b0);
        chk("stall_rst_cnt", pre_counter_o, 2'b01);
        chk("stall_rst_mcnt", mispred_cnt_o, 32'd0);

        // Random traffic over a few indices and two tags.
        for (int c = 0; c < 500; c++) begin
            rst            = ($urandom_range(0, 60) == 0);
            stall_i        = ($urandom_range(0, 5) == 0);
            id_is_branch_i = 1'($urandom_range(0, 1));
            lk_pc_i        = rand_pc();
            if ($urandom_range(0, 2) != 0) begin
                upd(rand_pc(), 1'($urandom_range(0, 1)), rand_tgt(), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 32'h0);
                upd_pre_target_i = ($urandom_range(0, 1) == 1) ? upd_target_i : rand_tgt();
            end else begin
                no_upd();
            end
            step();
        end
        rst = 1'b0;
        stall_i = 1'b0;
        no_upd();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
